// File: rtl/m14k_ssram_ctl.sv
// Sequencer/arbiter for a single-port byte-writable SSRAM: init sweep,
// word stores, line reads and line refill bursts. Option: M14K_SSRAM_CTL_FAIR_EN.
module m14k_ssram_ctl #(
  parameter int LIdxSize       = 2,
  parameter int WordsPerLine   = 4,
  parameter int WIdxSize       = 2,
  parameter int BYTES_PER_WORD = 4,
  parameter int BITS_PER_BYTE  = 8
) (
  input  logic                                    gclk,
  input  logic                                    greset,
  input  logic                                    rd_req,
  input  logic [LIdxSize-1:0]                     rd_idx,
  output logic                                    rd_ack,
  output logic                                    rd_valid,
  input  logic                                    st_req,
  input  logic [LIdxSize-1:0]                     st_idx,
  input  logic [WIdxSize-1:0]                     st_word,
  input  logic [BYTES_PER_WORD-1:0]               st_be,
  input  logic [BYTES_PER_WORD*BITS_PER_BYTE-1:0] st_data,
  output logic                                    st_ack,
  input  logic                                    fill_req,
  input  logic [LIdxSize-1:0]                     fill_idx,
  output logic                                    fill_ack,
  input  logic                                    fill_valid,
  input  logic [BYTES_PER_WORD*BITS_PER_BYTE-1:0] fill_data,
  output logic                                    fill_done,
  output logic                                    init_done,
  output logic [LIdxSize-1:0]                     sram_line_idx,
  output logic [BYTES_PER_WORD*WordsPerLine-1:0]  sram_wr_mask,
  output logic                                    sram_rd_str,
  output logic                                    sram_wr_str,
  output logic [BYTES_PER_WORD*BITS_PER_BYTE-1:0] sram_wr_data
);

  localparam int Depth = 2 ** LIdxSize;
  localparam int MW    = BYTES_PER_WORD * WordsPerLine;
  localparam int DW    = BYTES_PER_WORD * BITS_PER_BYTE;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_FILL = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [LIdxSize-1:0] init_cnt_q, init_cnt_d;
  logic [WIdxSize-1:0] fill_cnt_q, fill_cnt_d;
  logic [LIdxSize-1:0] fill_idx_q, fill_idx_d;
  logic                rd_valid_q, rd_valid_d;
  logic                fill_done_q, fill_done_d;
  logic                init_done_q, init_done_d;
  logic                st_win;
  logic [MW-1:0]       word_ones;

  assign word_ones = MW'({BYTES_PER_WORD{1'b1}});

`ifdef M14K_SSRAM_CTL_FAIR_EN
  logic last_rd_q, last_rd_d;
  // Store wins a tie only if the read was granted last
  always_comb begin
    st_win = st_req && (!rd_req || last_rd_q);
  end
`else
  // Store always beats read
  always_comb begin
    st_win = st_req;
  end
`endif

  // Next-state, grants and SRAM pin drive
  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    fill_cnt_d    = fill_cnt_q;
    fill_idx_d    = fill_idx_q;
    rd_valid_d    = 1'b0;
    fill_done_d   = 1'b0;
    init_done_d   = init_done_q;
    rd_ack        = 1'b0;
    st_ack        = 1'b0;
    fill_ack      = 1'b0;
    sram_line_idx = '0;
    sram_wr_mask  = '0;
    sram_rd_str   = 1'b0;
    sram_wr_str   = 1'b0;
    sram_wr_data  = '0;
`ifdef M14K_SSRAM_CTL_FAIR_EN
    last_rd_d     = last_rd_q;
`endif
    unique case (state_q)
      S_INIT: begin
        sram_wr_str   = 1'b1;
        sram_line_idx = init_cnt_q;
        sram_wr_mask  = '1;
        init_cnt_d    = init_cnt_q + 1'b1;
        if (init_cnt_q == LIdxSize'(Depth - 1)) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end
      end
      S_IDLE: begin
        if (fill_req) begin
          fill_ack   = 1'b1;
          fill_idx_d = fill_idx;
          fill_cnt_d = '0;
          state_d    = S_FILL;
        end else if (st_win) begin
          st_ack        = 1'b1;
          sram_wr_str   = 1'b1;
          sram_line_idx = st_idx;
          sram_wr_mask  = MW'(st_be) << (st_word * BYTES_PER_WORD);
          sram_wr_data  = st_data;
`ifdef M14K_SSRAM_CTL_FAIR_EN
          last_rd_d     = 1'b0;
`endif
        end else if (rd_req) begin
          rd_ack        = 1'b1;
          sram_rd_str   = 1'b1;
          sram_line_idx = rd_idx;
          rd_valid_d    = 1'b1;
`ifdef M14K_SSRAM_CTL_FAIR_EN
          last_rd_d     = 1'b1;
`endif
        end
      end
      S_FILL: begin
        if (fill_valid) begin
          sram_wr_str   = 1'b1;
          sram_line_idx = fill_idx_q;
          sram_wr_mask  = word_ones << (fill_cnt_q * BYTES_PER_WORD);
          sram_wr_data  = fill_data;
          fill_cnt_d    = fill_cnt_q + 1'b1;
          if (fill_cnt_q == WIdxSize'(WordsPerLine - 1)) begin
            state_d     = S_IDLE;
            fill_done_d = 1'b1;
          end
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge gclk or posedge greset) begin
    if (greset) begin
      state_q     <= S_INIT;
      init_cnt_q  <= '0;
      fill_cnt_q  <= '0;
      fill_idx_q  <= '0;
      rd_valid_q  <= 1'b0;
      fill_done_q <= 1'b0;
      init_done_q <= 1'b0;
`ifdef M14K_SSRAM_CTL_FAIR_EN
      last_rd_q   <= 1'b1;
`endif
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      fill_cnt_q  <= fill_cnt_d;
      fill_idx_q  <= fill_idx_d;
      rd_valid_q  <= rd_valid_d;
      fill_done_q <= fill_done_d;
      init_done_q <= init_done_d;
`ifdef M14K_SSRAM_CTL_FAIR_EN
      last_rd_q   <= last_rd_d;
`endif
    end
  end

  assign rd_valid  = rd_valid_q;
  assign fill_done = fill_done_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_m14k_ssram_ctl.sv
// Bench for m14k_ssram_ctl: behavioural SRAM, write/read scoreboards,
// directed arbitration, fill, reset and read-pipelining scenarios.
module tb_m14k_ssram_ctl;

  localparam int LI = 2;
  localparam int WI = 2;
  localparam int NW = 4;
  localparam int BW = 4;
  localparam int DW = 32;
  localparam int MW = BW * NW;
  localparam int LW = DW * NW;

  typedef struct packed {
    logic [LI-1:0] idx;
    logic [MW-1:0] mask;
    logic [DW-1:0] data;
  } wr_t;

  logic          gclk = 1'b0;
  logic          greset;
  logic          rd_req, st_req, fill_req, fill_valid;
  logic [LI-1:0] rd_idx, st_idx, fill_idx;
  logic [WI-1:0] st_word;
  logic [BW-1:0] st_be;
  logic [DW-1:0] st_data, fill_data;
  logic          rd_ack, rd_valid, st_ack, fill_ack;
  logic          fill_done, init_done;
  logic [LI-1:0] sram_line_idx;
  logic [MW-1:0] sram_wr_mask;
  logic          sram_rd_str, sram_wr_str;
  logic [DW-1:0] sram_wr_data;

  logic [LW-1:0] mem [4];
  logic [LW-1:0] ref_mem [4];
  logic [LW-1:0] rd_data;

  wr_t           wq[$];
  logic [LW-1:0] rq[$];

  int n_chk  = 0;
  int n_pass = 0;

  m14k_ssram_ctl dut (
    .gclk(gclk), .greset(greset),
    .rd_req(rd_req), .rd_idx(rd_idx), .rd_ack(rd_ack),
    .rd_valid(rd_valid),
    .st_req(st_req), .st_idx(st_idx), .st_word(st_word),
    .st_be(st_be), .st_data(st_data), .st_ack(st_ack),
    .fill_req(fill_req), .fill_idx(fill_idx),
    .fill_ack(fill_ack), .fill_valid(fill_valid),
    .fill_data(fill_data), .fill_done(fill_done),
    .init_done(init_done),
    .sram_line_idx(sram_line_idx),
    .sram_wr_mask(sram_wr_mask),
    .sram_rd_str(sram_rd_str), .sram_wr_str(sram_wr_str),
    .sram_wr_data(sram_wr_data)
  );

  always #5 gclk = ~gclk;

  task automatic chk(input string tag,
                     input logic [LW-1:0] got,
                     input logic [LW-1:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // SRAM macro model: byte-masked write, one-cycle read latency
  always @(posedge gclk) begin
    if (sram_rd_str) rd_data <= mem[sram_line_idx];
    else if (sram_wr_str) rd_data <= 'x;
    if (sram_wr_str)
      for (int b = 0; b < MW; b++)
        if (sram_wr_mask[b])
          mem[sram_line_idx][b*8 +: 8] <=
            sram_wr_data[(b%BW)*8 +: 8];
  end

  // Scoreboard against SRAM pins and read data
  always @(negedge gclk) begin
    if (!greset) begin
      chk("one_str", 128'(sram_wr_str & sram_rd_str), 128'd0);
      if (sram_wr_str) begin
        chk("wq_nonempty", 128'(wq.size() != 0), 128'd1);
        if (wq.size() != 0) begin
          wr_t e;
          e = wq.pop_front();
          chk("wr_idx", 128'(sram_line_idx), 128'(e.idx));
          chk("wr_mask", 128'(sram_wr_mask), 128'(e.mask));
          chk("wr_data", 128'(sram_wr_data), 128'(e.data));
        end
      end else if (!sram_rd_str) begin
        chk("idle_pins",
            128'({sram_line_idx, sram_wr_mask, sram_wr_data}),
            128'd0);
      end
      if (rd_valid) begin
        chk("rq_nonempty", 128'(rq.size() != 0), 128'd1);
        if (rq.size() != 0) chk("rd_data", rd_data, rq.pop_front());
      end
    end
  end

  task automatic exp_wr(input logic [LI-1:0] idx,
                        input logic [MW-1:0] mask,
                        input logic [DW-1:0] data);
    wr_t e;
    e.idx = idx; e.mask = mask; e.data = data;
    wq.push_back(e);
    for (int b = 0; b < MW; b++)
      if (mask[b]) ref_mem[idx][b*8 +: 8] = data[(b%BW)*8 +: 8];
  endtask

  task automatic exp_init();
    for (int i = 0; i < 4; i++) exp_wr(LI'(i), '1, '0);
  endtask

  task automatic nxt();
    @(posedge gclk);
    #1;
  endtask

  task automatic chk_acks(input string tag, input logic f,
                          input logic s, input logic r);
    chk({tag, "_fill_ack"}, 128'(fill_ack), 128'(f));
    chk({tag, "_st_ack"}, 128'(st_ack), 128'(s));
    chk({tag, "_rd_ack"}, 128'(rd_ack), 128'(r));
  endtask

  task automatic do_init(input string tag);
    exp_init();
    greset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge gclk);
      chk({tag, "_init_done"}, 128'(init_done), 128'(i == 4));
      chk({tag, "_fill_done"}, 128'(fill_done), 128'd0);
      if (i < 4) chk_acks(tag, 1'b0, 1'b0, 1'b0);
      nxt();
    end
  endtask

  initial begin
    logic [LW-1:0] lit;
    logic [DW-1:0] fw [4];
    logic          fv [6];
    int            k;
    greset = 1'b1;
    {rd_req, st_req, fill_req, fill_valid} = '0;
    rd_idx = '0; st_idx = '0; fill_idx = '0; st_word = '0;
    st_be = '0; st_data = '0; fill_data = '0;
    repeat (3) @(posedge gclk);
    #1;
    chk("rst_init_done", 128'(init_done), 128'd0);
    chk("rst_rd_valid", 128'(rd_valid), 128'd0);
    chk("rst_fill_done", 128'(fill_done), 128'd0);

    // Read held through init: granted only once sweep ends
    rd_req = 1'b1; rd_idx = 2'd0;
    exp_init();
    greset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge gclk);
      chk("init_done", 128'(init_done), 128'(i == 4));
      chk_acks("init", 1'b0, 1'b0, i == 4);
      if (i == 4) rq.push_back(ref_mem[0]);
      nxt();
    end
    rd_req = 1'b0;

    // Byte-enabled store then read back
    st_req = 1'b1; st_idx = 2'd2; st_word = 2'd1;
    st_be = 4'b0110; st_data = 32'hA5A5A5A5;
    exp_wr(2'd2, 16'h0060, 32'hA5A5A5A5);
    @(negedge gclk);
    chk_acks("st", 1'b0, 1'b1, 1'b0);
    chk("st_mask", 128'(sram_wr_mask), 128'h0060);
    nxt();
    st_req = 1'b0;
    rd_req = 1'b1; rd_idx = 2'd2;
    rq.push_back(ref_mem[2]);
    @(negedge gclk);
    chk_acks("rd", 1'b0, 1'b0, 1'b1);
    nxt();
    rd_req = 1'b0;
    @(negedge gclk);
    lit = 128'h00000000_00000000_00A5A500_00000000;
    chk("rd2_valid", 128'(rd_valid), 128'd1);
    chk("rd2_lit", rd_data, lit);
    nxt();
    @(negedge gclk);
    chk("rd_valid_drop", 128'(rd_valid), 128'd0);
    nxt();

    // Fill beats store and read; gap of two cycles after word 1
    fill_req = 1'b1; fill_idx = 2'd1;
    st_req = 1'b1; st_idx = 2'd3; st_word = 2'd0;
    st_be = 4'hF; st_data = 32'hDEADBEEF;
    rd_req = 1'b1; rd_idx = 2'd1;
    @(negedge gclk);
    chk_acks("fgrant", 1'b1, 1'b0, 1'b0);
    chk("fgrant_str", 128'({sram_wr_str, sram_rd_str}), 128'd0);
    nxt();
    fill_req = 1'b0;
    fw = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    fv = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    k = 0;
    for (int c = 0; c < 6; c++) begin
      fill_valid = fv[c];
      fill_data = fv[c] ? fw[k] : 32'h0;
      if (fv[c]) exp_wr(2'd1, 16'hF << (4 * k), fw[k]);
      @(negedge gclk);
      chk_acks("fill", 1'b0, 1'b0, 1'b0);
      chk("fill_str", 128'(sram_wr_str), 128'(fv[c]));
      chk("fill_done_early", 128'(fill_done), 128'd0);
      if (fv[c]) k++;
      nxt();
    end
    fill_valid = 1'b0;
    exp_wr(2'd3, 16'h000F, 32'hDEADBEEF);
    @(negedge gclk);
    chk("fill_done", 128'(fill_done), 128'd1);
    chk_acks("post_fill", 1'b0, 1'b1, 1'b0);
    nxt();
    st_req = 1'b0;
    rq.push_back(ref_mem[1]);
    @(negedge gclk);
    chk("fill_done_pulse", 128'(fill_done), 128'd0);
    chk_acks("post_fill_rd", 1'b0, 1'b0, 1'b1);
    nxt();
    rd_req = 1'b0;

    // Store and read contending for four cycles
    st_req = 1'b1; rd_req = 1'b1;
    st_idx = 2'd0; st_word = 2'd2; st_be = 4'h1; rd_idx = 2'd0;
    for (int c = 0; c < 4; c++) begin
      logic es;
`ifdef M14K_SSRAM_CTL_FAIR_EN
      es = (c % 2) == 0;
`else
      es = 1'b1;
`endif
      st_data = 32'(c + 8'h50);
      if (es) exp_wr(2'd0, 16'h0100, st_data);
      else rq.push_back(ref_mem[0]);
      @(negedge gclk);
      chk_acks("tie", 1'b0, es, !es);
      nxt();
    end
    st_req = 1'b0; rd_req = 1'b0;
    nxt();

    // Reset in the middle of a fill
    fill_req = 1'b1; fill_idx = 2'd2;
    @(negedge gclk);
    chk_acks("f2grant", 1'b1, 1'b0, 1'b0);
    nxt();
    fill_req = 1'b0;
    for (int c = 0; c < 2; c++) begin
      fill_valid = 1'b1;
      fill_data = 32'(32'hC0DE0000 + c);
      exp_wr(2'd2, 16'hF << (4 * c), fill_data);
      nxt();
    end
    fill_valid = 1'b0;
    #2;
    greset = 1'b1;
    #1;
    chk("arst_init_done", 128'(init_done), 128'd0);
    chk("arst_fill_done", 128'(fill_done), 128'd0);
    chk("arst_idx", 128'(sram_line_idx), 128'd0);
    nxt();
    nxt();
    do_init("reinit");
    @(negedge gclk);
    chk("reinit_fill_done", 128'(fill_done), 128'd0);
    nxt();

    // Distinct lines 0 and 3, then back-to-back reads
    st_req = 1'b1; st_idx = 2'd3; st_word = 2'd3;
    st_be = 4'hF; st_data = 32'h12345678;
    exp_wr(2'd3, 16'hF000, st_data);
    nxt();
    st_idx = 2'd0; st_word = 2'd0; st_data = 32'hCAFEF00D;
    exp_wr(2'd0, 16'h000F, st_data);
    nxt();
    st_req = 1'b0;
    rd_req = 1'b1; rd_idx = 2'd0;
    rq.push_back(ref_mem[0]);
    @(negedge gclk);
    chk_acks("b2b0", 1'b0, 1'b0, 1'b1);
    nxt();
    rd_idx = 2'd3;
    rq.push_back(ref_mem[3]);
    @(negedge gclk);
    chk_acks("b2b1", 1'b0, 1'b0, 1'b1);
    chk("b2b_valid0", 128'(rd_valid), 128'd1);
    nxt();
    rd_req = 1'b0;
    @(negedge gclk);
    chk("b2b_valid1", 128'(rd_valid), 128'd1);
    nxt();
    @(negedge gclk);
    chk("b2b_valid2", 128'(rd_valid), 128'd0);
    nxt();

    repeat (2) nxt();
    chk("wq_drained", 128'(wq.size()), 128'd0);
    chk("rq_drained", 128'(rq.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
